// File: rtl/reg_bank_ctrl.sv
// Register bank behind a sel/wr/ready bus: byte strobes, W1C upper region,
// programmable read latency with rvalid, and err for out-of-range addresses.
//
// state   | meaning
// IDLE    | ready; writes commit here, reads snapshot and leave
// RD_WAIT | read latency padding, RD_LATENCY-1 cycles via down-counter
// RD_RESP | rvalid/rdata (and err if out of range) presented for one cycle
module reg_bank_ctrl #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter int                    W1C_BASE   = DEPTH,
  parameter int                    RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sel,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] WAIT_LD = 2'((RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("reg_bank_ctrl: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
    $error("reg_bank_ctrl: RD_LATENCY must be in 1..4");
  end
  if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_chk_depth
    $error("reg_bank_ctrl: DEPTH exceeds address space");
  end
  if (W1C_BASE > DEPTH) begin : g_chk_w1c
    $error("reg_bank_ctrl: W1C_BASE must not exceed DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] snap;
  logic                  snap_err;
  logic                  wr_err;
  logic                  accept;
  logic                  in_range;
  logic                  is_w1c;
  logic [IDX_W-1:0]      idx;

  assign ready    = (state == IDLE);
  assign accept   = sel & ready;
  assign in_range = (32'(addr) < 32'(DEPTH));
  assign is_w1c   = (32'(addr) >= 32'(W1C_BASE));
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept && !wr) begin
          if (RD_LATENCY == 1) begin
            state_nxt = RD_RESP;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = WAIT_LD;
          end
        end
      end
      RD_WAIT: begin
        if (cnt == 2'd0) state_nxt = RD_RESP;
        else             cnt_nxt   = cnt - 2'd1;
      end
      RD_RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: storage, read snapshot and the write-error strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap     <= '0;
      snap_err <= 1'b0;
      wr_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else begin
      wr_err <= accept & wr & ~in_range;
      if (accept && !wr) begin
        snap     <= in_range ? mem[idx] : '0;
        snap_err <= ~in_range;
      end
      if (accept && wr && in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb[b]) begin
            if (is_w1c) mem[idx][8*b +: 8] <= mem[idx][8*b +: 8] & ~wdata[8*b +: 8];
            else        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Gated by rstn so a reset mid-read suppresses the response at once
  assign rvalid = rstn & (state == RD_RESP);
  assign rdata  = rvalid ? snap : '0;
  assign err    = rstn & ((rvalid & snap_err) | wr_err);

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: four instances, RD_LATENCY 1..4, each with
// its own parameter set, exercised one at a time against hand-computed values.
module tb_reg_bank_ctrl;

  logic             clk = 1'b0;
  logic [3:0]       rstn, sel, wr, ready, rvalid, err;
  logic [3:0][7:0]  addr;
  logic [3:0][31:0] wdata, rdata;
  logic [3:0][3:0]  wstrb;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  inst;
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  reg_bank_ctrl #(.DEPTH(256), .RESET_VAL(32'hFFFF_FFFF), .W1C_BASE(8'hF0), .RD_LATENCY(1)) u0 (
    .clk(clk), .rstn(rstn[0]), .sel(sel[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .ready(ready[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .err(err[0]));
  reg_bank_ctrl #(.DEPTH(200), .RESET_VAL(32'h0), .W1C_BASE(200), .RD_LATENCY(2)) u1 (
    .clk(clk), .rstn(rstn[1]), .sel(sel[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .ready(ready[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .err(err[1]));
  reg_bank_ctrl #(.DEPTH(256), .RESET_VAL(32'h1234_5678), .RD_LATENCY(3)) u2 (
    .clk(clk), .rstn(rstn[2]), .sel(sel[2]), .wr(wr[2]), .addr(addr[2]), .wdata(wdata[2]),
    .wstrb(wstrb[2]), .ready(ready[2]), .rdata(rdata[2]), .rvalid(rvalid[2]), .err(err[2]));
  reg_bank_ctrl #(.DEPTH(256), .RESET_VAL(32'h5A5A_0001), .RD_LATENCY(4)) u3 (
    .clk(clk), .rstn(rstn[3]), .sel(sel[3]), .wr(wr[3]), .addr(addr[3]), .wdata(wdata[3]),
    .wstrb(wstrb[3]), .ready(ready[3]), .rdata(rdata[3]), .rvalid(rvalid[3]), .err(err[3]));

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per response strobe on any instance
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rvalid[k] || err[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp inst=%0d actual rvalid=%b err=%b required=none", k, rvalid[k], err[k]);
        end else begin
          e = exp_q.pop_front();
          check("resp_inst", 32'(k), 32'(e.inst));
          check("resp_rvalid", 32'(rvalid[k]), 32'(e.is_read));
          check("resp_err", 32'(err[k]), 32'(e.err));
          check("resp_rdata", rdata[k], e.data);
        end
      end else begin
        check("idle_rdata", rdata[k], 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(int k);
    int n = 0;
    while (!ready[k] && n < 50) begin
      tick();
      n++;
    end
    if (!ready[k]) begin
      checks++;
      failures++;
      $display("FAIL wait_ready inst=%0d actual=0 required=1", k);
    end
  endtask

  task automatic do_write(int k, logic [7:0] a, logic [31:0] d, logic [3:0] s, bit exp_err);
    exp_t e;
    wait_ready(k);
    if (exp_err) begin
      e = '{inst: 2'(k), is_read: 1'b0, err: 1'b1, data: 32'h0};
      exp_q.push_back(e);
    end
    sel[k] = 1'b1; wr[k] = 1'b1; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    tick();
    sel[k] = 1'b0; wr[k] = 1'b0;
  endtask

  // Single read with ready/rvalid timing checked cycle by cycle; latency is k+1
  task automatic do_read(int k, logic [7:0] a, logic [31:0] d, bit exp_err);
    exp_t e;
    int rl = k + 1;
    wait_ready(k);
    e = '{inst: 2'(k), is_read: 1'b1, err: exp_err, data: d};
    exp_q.push_back(e);
    sel[k] = 1'b1; wr[k] = 1'b0; addr[k] = a;
    tick();
    sel[k] = 1'b0;
    for (int m = 0; m <= rl; m++) begin
      check("rd_ready", 32'(ready[k]), 32'(m == rl));
      check("rd_rvalid", 32'(rvalid[k]), 32'(m == rl - 1));
      if (m < rl) tick();
    end
  endtask

  // sel held high for three read periods: accepts at offsets 0, rl+1, 2(rl+1)
  task automatic sweep(int k, logic [7:0] a, logic [31:0] d);
    exp_t e;
    int rl = k + 1;
    wait_ready(k);
    e = '{inst: 2'(k), is_read: 1'b1, err: 1'b0, data: d};
    for (int i = 0; i < 3; i++) exp_q.push_back(e);
    sel[k] = 1'b1; wr[k] = 1'b0; addr[k] = a;
    for (int m = 0; m < 3 * (rl + 1); m++) begin
      tick();
      check("sweep_ready", 32'(ready[k]), 32'((m % (rl + 1)) == rl));
      check("sweep_rvalid", 32'(rvalid[k]), 32'((m % (rl + 1)) == rl - 1));
    end
    sel[k] = 1'b0;
  endtask

  initial begin
    rstn = '0; sel = '0; wr = '0; addr = '0; wdata = '0; wstrb = '0;
    tick();
    tick();
    rstn = '1;
    for (int k = 0; k < 4; k++) begin
      check("rst_ready", 32'(ready[k]), 32'h1);
      check("rst_rvalid", 32'(rvalid[k]), 32'h0);
      check("rst_err", 32'(err[k]), 32'h0);
      check("rst_rdata", rdata[k], 32'h0);
    end

    // Reset value and read timing at RD_LATENCY=4
    do_read(3, 8'h05, 32'h5A5A_0001, 1'b0);

    // Byte strobes
    do_write(1, 8'h10, 32'hAABB_CCDD, 4'hF, 1'b0);
    do_write(1, 8'h10, 32'h1122_3344, 4'b0101, 1'b0);
    do_read(1, 8'h10, 32'hAA22_CC44, 1'b0);
    do_write(1, 8'h10, 32'hFFFF_FFFF, 4'h0, 1'b0);
    do_read(1, 8'h10, 32'hAA22_CC44, 1'b0);
    do_write(2, 8'h20, 32'hCAFE_F00D, 4'b1000, 1'b0);
    do_read(2, 8'h20, 32'hCA34_5678, 1'b0);

    // W1C region starting at 0xF0, reset value all ones
    do_read(0, 8'hF0, 32'hFFFF_FFFF, 1'b0);
    do_write(0, 8'hF0, 32'h0000_FFFF, 4'hF, 1'b0);
    do_read(0, 8'hF0, 32'hFFFF_0000, 1'b0);
    do_write(0, 8'hF0, 32'h0F0F_0F0F, 4'hF, 1'b0);
    do_read(0, 8'hF0, 32'hF0F0_0000, 1'b0);
    do_read(0, 8'hF0, 32'hF0F0_0000, 1'b0);
    do_write(0, 8'hF0, 32'hFFFF_FFFF, 4'b0100, 1'b0);
    do_read(0, 8'hF0, 32'hF000_0000, 1'b0);
    do_write(0, 8'hF0, 32'hFFFF_FFFF, 4'h0, 1'b0);
    do_read(0, 8'hF0, 32'hF000_0000, 1'b0);
    do_write(0, 8'hEF, 32'h0000_FFFF, 4'hF, 1'b0);
    do_read(0, 8'hEF, 32'h0000_FFFF, 1'b0);

    // Out of range with DEPTH=200
    do_write(1, 8'hC8, 32'hDEAD_BEEF, 4'hF, 1'b1);
    do_read(1, 8'h00, 32'h0, 1'b0);
    do_read(1, 8'hC7, 32'h0, 1'b0);
    do_write(1, 8'hC7, 32'h0102_0304, 4'hF, 1'b0);
    do_read(1, 8'hC7, 32'h0102_0304, 1'b0);
    do_read(1, 8'hC8, 32'h0, 1'b1);
    do_read(1, 8'hFF, 32'h0, 1'b1);

    // Reset during RD_WAIT aborts the read and restores entries
    do_write(3, 8'h05, 32'h1111_1111, 4'hF, 1'b0);
    do_read(3, 8'h05, 32'h1111_1111, 1'b0);
    wait_ready(3);
    sel[3] = 1'b1; wr[3] = 1'b0; addr[3] = 8'h05;
    tick();
    sel[3] = 1'b0;
    tick();
    rstn[3] = 1'b0;
    check("abort_rvalid", 32'(rvalid[3]), 32'h0);
    tick();
    rstn[3] = 1'b1;
    check("abort_ready", 32'(ready[3]), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    do_read(3, 8'h05, 32'h5A5A_0001, 1'b0);

    // Continuous sel at every latency
    sweep(0, 8'h01, 32'hFFFF_FFFF);
    sweep(1, 8'h10, 32'hAA22_CC44);
    sweep(2, 8'h20, 32'hCA34_5678);
    sweep(3, 8'h05, 32'h5A5A_0001);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
